// File: rtl/cpu_ula_issuer.sv
// Instruction issuer in front of the ALU: decodes one instruction at a time, reads
// operands from an 8x16 register file, runs the ALU handshake and writes back the result.
module cpu_ula_issuer #(
  parameter int TIMEOUT_CYC = 8,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  alu_op_code,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        busy,
  output logic        err_illegal,
  output logic        err_timeout,
  input  logic [2:0]  dbg_rd_addr,
  output logic [15:0] dbg_rd_data
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_PREP,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        rd_q, rd_d;
  logic [15:0]       opa_q, opa_d;
  logic [15:0]       opb_q, opb_d;
  logic [15:0]       res_q, res_d;
  logic              wr_en_q, wr_en_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]        alu_op_code_q, alu_op_code_d;
  logic [15:0]       alu_src1_q, alu_src1_d;
  logic [15:0]       alu_src2_q, alu_src2_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_timeout_q, err_timeout_d;
  logic [7:0][15:0]  regs_q, regs_d;

  logic [2:0] dec_op, dec_rd, dec_rs1, dec_rs2;
  logic [6:0] dec_imm7;
  logic [9:0] dec_imm10;

  assign dec_op    = instr_q[15:13];
  assign dec_rd    = instr_q[12:10];
  assign dec_rs1   = instr_q[9:7];
  assign dec_rs2   = instr_q[6:4];
  assign dec_imm7  = instr_q[6:0];
  assign dec_imm10 = instr_q[9:0];

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    op_d          = op_q;
    rd_d          = rd_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    res_d         = res_q;
    wr_en_d       = wr_en_q;
    cnt_d         = cnt_q;
    alu_op_code_d = alu_op_code_q;
    alu_src1_d    = alu_src1_q;
    alu_src2_d    = alu_src2_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    regs_d        = regs_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d  = dec_op;
        rd_d  = dec_rd;
        opa_d = regs_q[dec_rs1];
        // imm7 keeps its top bit untouched; the ALU treats it as a sign-magnitude flag
        if (dec_op == OP_ADDI || dec_op == OP_SUBI) opb_d = {9'b0, dec_imm7};
        else                                        opb_d = regs_q[dec_rs2];
        case (dec_op)
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL: begin
            wr_en_d = (dec_rd != 3'd0);
            state_d = S_PREP;
          end
          OP_LDI: begin
            res_d   = {6'b0, dec_imm10};
            wr_en_d = (dec_rd != 3'd0);
            state_d = S_WB;
          end
          OP_ILL: begin
            err_illegal_d = 1'b1;
            wr_en_d       = 1'b0;
            state_d       = S_WB;
          end
          default: begin
            wr_en_d = 1'b0;
            state_d = S_WB;
          end
        endcase
      end
      S_PREP: begin
        alu_src1_d    = opa_q;
        alu_src2_d    = opb_q;
        alu_op_code_d = op_q;
        state_d       = S_ISSUE;
      end
      S_ISSUE: begin
        alu_op_code_d = OP_NOP;
        cnt_d         = '0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          res_d   = alu_result;
          cnt_d   = '0;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        if (wr_en_q) regs_d[rd_q] = res_q;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      res_q         <= '0;
      wr_en_q       <= 1'b0;
      cnt_q         <= '0;
      alu_op_code_q <= '0;
      alu_src1_q    <= '0;
      alu_src2_q    <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      regs_q        <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      res_q         <= res_d;
      wr_en_q       <= wr_en_d;
      cnt_q         <= cnt_d;
      alu_op_code_q <= alu_op_code_d;
      alu_src1_q    <= alu_src1_d;
      alu_src2_q    <= alu_src2_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      regs_q        <= regs_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_op_code = alu_op_code_q;
  assign alu_src1    = alu_src1_q;
  assign alu_src2    = alu_src2_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign dbg_rd_data = regs_q[dbg_rd_addr];

endmodule

// File: tb/tb_cpu_ula_issuer.sv
// Directed bench for cpu_ula_issuer: the bench plays the ALU and checks timing,
// operands, writeback, error flags and reset behaviour against hand-computed values.
module tb_cpu_ula_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_op_code;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        busy;
  logic        err_illegal;
  logic        err_timeout;
  logic [2:0]  dbg_rd_addr;
  logic [15:0] dbg_rd_data;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_r [8];

  cpu_ula_issuer #(.TIMEOUT_CYC(8), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_op_code(alu_op_code), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_done(alu_done),
    .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction while IDLE; returns 1ns after the accepting edge E.
  task automatic accept(input logic [15:0] i);
    instr       = i;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
    dbg_rd_addr = a;
    #1;
    d = dbg_rd_data;
  endtask

  task automatic ldi(input logic [2:0] rd, input logic [9:0] imm);
    accept({3'b110, rd, imm});
    tick();
    tick();
    if (rd != 3'd0) exp_r[rd] = {6'b0, imm};
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (alu_op_code !== 3'b000) begin fails++; $display("FAIL reset_opcode got %b exp 000", alu_op_code); end
    tests++; if ({alu_src1, alu_src2} !== 32'h0) begin fails++; $display("FAIL reset_src got %h exp 0", {alu_src1, alu_src2}); end
    tests++; if ({err_illegal, err_timeout} !== 2'b00) begin fails++; $display("FAIL reset_err got %b exp 00", {err_illegal, err_timeout}); end
    for (int i = 0; i < 8; i++) begin
      rd_reg(i[2:0], d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reset_reg%0d got %h exp 0000", i, d); end
    end
  endtask

  task automatic test_ldi_add();
    logic [15:0] d;
    int op_cycles;
    accept({3'b110, 3'd1, 10'd5});
    tests++; if ({busy, instr_ready} !== 2'b10) begin fails++; $display("FAIL ldi_busy got %b exp 10", {busy, instr_ready}); end
    tick();
    rd_reg(3'd1, d);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL ldi_old_value got %h exp 0000", d); end
    tick();
    rd_reg(3'd1, d);
    tests++; if (d !== 16'd5) begin fails++; $display("FAIL ldi_r1 got %h exp 0005", d); end
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL ldi_ready got %b exp 1", instr_ready); end
    exp_r[1] = 16'd5;
    ldi(3'd2, 10'd3);

    op_cycles = 0;
    accept({3'b001, 3'd3, 3'd1, 3'd2, 4'b0000});
    if (alu_op_code == 3'b001) op_cycles++;
    tick();
    if (alu_op_code == 3'b001) op_cycles++;
    tick();
    tests++; if (alu_op_code !== 3'b001) begin fails++; $display("FAIL add_opcode_e2 got %b exp 001", alu_op_code); end
    tests++; if (alu_src1 !== 16'd5 || alu_src2 !== 16'd3) begin fails++; $display("FAIL add_src got %h/%h exp 0005/0003", alu_src1, alu_src2); end
    if (alu_op_code == 3'b001) op_cycles++;
    tick();
    if (alu_op_code == 3'b001) op_cycles++;
    tick();
    if (alu_op_code == 3'b001) op_cycles++;
    alu_result = exp_r[1] + exp_r[2];
    alu_done   = 1'b1;
    tick();
    alu_done = 1'b0;
    if (alu_op_code == 3'b001) op_cycles++;
    rd_reg(3'd3, d);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL add_r3_before_wb got %h exp 0000", d); end
    tick();
    rd_reg(3'd3, d);
    tests++; if (d !== 16'd8) begin fails++; $display("FAIL add_r3 got %h exp 0008", d); end
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL add_ready_e6 got %b exp 1", instr_ready); end
    tests++; if (op_cycles !== 1) begin fails++; $display("FAIL add_opcode_cycles got %0d exp 1", op_cycles); end
    exp_r[3] = 16'd8;
  endtask

  // ALU done raised during ISSUE must be ignored there and complete on the first WAIT cycle.
  task automatic test_subi();
    logic [15:0] d;
    ldi(3'd1, 10'd10);
    accept({3'b100, 3'd4, 3'd1, 7'h42});
    tick();
    tick();
    tests++; if (alu_op_code !== 3'b100) begin fails++; $display("FAIL subi_opcode got %b exp 100", alu_op_code); end
    tests++; if (alu_src1 !== 16'd10 || alu_src2 !== 16'h0042) begin fails++; $display("FAIL subi_src got %h/%h exp 000a/0042", alu_src1, alu_src2); end
    alu_result = 16'd12;
    alu_done   = 1'b1;
    tick();
    tick();
    alu_done = 1'b0;
    rd_reg(3'd4, d);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL subi_r4_early got %h exp 0000", d); end
    tick();
    rd_reg(3'd4, d);
    tests++; if (d !== 16'd12) begin fails++; $display("FAIL subi_r4 got %h exp 000c", d); end
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL subi_ready got %b exp 1", instr_ready); end
    exp_r[4] = 16'd12;
  endtask

  task automatic test_mul();
    logic [15:0] d;
    logic [31:0] full;
    ldi(3'd1, 10'h100);
    ldi(3'd2, 10'h100);
    ldi(3'd5, 10'd7);
    full = {16'h0, exp_r[1]} * {16'h0, exp_r[2]};
    accept({3'b101, 3'd5, 3'd1, 3'd2, 4'b0000});
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mul_busy_e0 got %b exp 1", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) begin
        tests++; if (alu_src1 !== 16'h0100 || alu_op_code !== 3'b101) begin fails++; $display("FAIL mul_issue got %h/%b exp 0100/101", alu_src1, alu_op_code); end
      end
      if (k == 4) begin alu_result = full[15:0]; alu_done = 1'b1; end
      if (k == 5) alu_done = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mul_busy_e%0d got %b exp 1", k, busy); end
    end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mul_busy_e6 got %b exp 0", busy); end
    rd_reg(3'd5, d);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL mul_r5 got %h exp 0000", d); end
    exp_r[5] = 16'h0000;
  endtask

  task automatic test_rd0();
    logic [15:0] d;
    accept({3'b001, 3'd0, 3'd1, 3'd2, 4'b0000});
    tick();
    tick();
    tests++; if (alu_op_code !== 3'b001) begin fails++; $display("FAIL rd0_opcode got %b exp 001", alu_op_code); end
    tick();
    tick();
    alu_result = 16'hBEEF;
    alu_done   = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    rd_reg(3'd0, d);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL rd0_r0 got %h exp 0000", d); end
  endtask

  task automatic test_illegal();
    logic [15:0] d;
    accept({3'b111, 3'd3, 10'h3FF});
    tick();
    tests++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL ill_flag got %b exp 1", err_illegal); end
    tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL ill_ready_e1 got %b exp 0", instr_ready); end
    tick();
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL ill_ready_e2 got %b exp 1", instr_ready); end
    for (int i = 0; i < 8; i++) begin
      rd_reg(i[2:0], d);
      tests++; if (d !== exp_r[i]) begin fails++; $display("FAIL ill_reg%0d got %h exp %h", i, d, exp_r[i]); end
    end
  endtask

  task automatic test_nop();
    logic [15:0] d;
    accept({3'b000, 3'd2, 10'h155});
    tick();
    tick();
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL nop_ready got %b exp 1", instr_ready); end
    rd_reg(3'd2, d);
    tests++; if (d !== exp_r[2]) begin fails++; $display("FAIL nop_r2 got %h exp %h", d, exp_r[2]); end
    tests++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL nop_sticky_ill got %b exp 1", err_illegal); end
  endtask

  task automatic test_timeout();
    logic [15:0] d;
    ldi(3'd6, 10'd9);
    accept({3'b011, 3'd6, 3'd1, 3'd2, 4'b0000});
    tick();
    tick();
    tests++; if (alu_op_code !== 3'b011) begin fails++; $display("FAIL to_opcode got %b exp 011", alu_op_code); end
    for (int k = 3; k <= 10; k++) tick();
    tests++; if ({instr_ready, err_timeout} !== 2'b00) begin fails++; $display("FAIL to_e10 got %b exp 00", {instr_ready, err_timeout}); end
    tick();
    tests++; if ({instr_ready, err_timeout} !== 2'b11) begin fails++; $display("FAIL to_e11 got %b exp 11", {instr_ready, err_timeout}); end
    rd_reg(3'd6, d);
    tests++; if (d !== 16'd9) begin fails++; $display("FAIL to_r6 got %h exp 0009", d); end
    alu_result = 16'h1234;
    alu_done   = 1'b1;
    tick();
    alu_done = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL to_late_done_busy got %b exp 0", busy); end
    rd_reg(3'd6, d);
    tests++; if (d !== 16'd9) begin fails++; $display("FAIL to_late_done_r6 got %h exp 0009", d); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    accept({3'b001, 3'd7, 3'd1, 3'd2, 4'b0000});
    for (int k = 1; k <= 4; k++) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy got %b exp 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    tests++; if ({instr_ready, busy} !== 2'b10) begin fails++; $display("FAIL rstmid_idle got %b exp 10", {instr_ready, busy}); end
    tests++; if (alu_op_code !== 3'b000 || alu_src1 !== 16'h0000) begin fails++; $display("FAIL rstmid_alu got %b/%h exp 000/0000", alu_op_code, alu_src1); end
    tests++; if ({err_illegal, err_timeout} !== 2'b00) begin fails++; $display("FAIL rstmid_err got %b exp 00", {err_illegal, err_timeout}); end
    for (int i = 0; i < 8; i++) begin
      rd_reg(i[2:0], d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL rstmid_reg%0d got %h exp 0000", i, d); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_result  = 16'h0000;
    alu_done    = 1'b0;
    dbg_rd_addr = 3'd0;
    test_reset();
    test_ldi_add();
    test_subi();
    test_mul();
    test_rd0();
    test_illegal();
    test_nop();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
